// File: rtl/disp_pkg.sv
// Shared constants, field layout and glyph table for the multiplexed
// 8-digit seven-segment scanner.
package disp_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int FW         = 6;
  localparam int BUS_W      = NUM_DIGITS * FW;

  localparam int EN_BIT  = 5;
  localparam int HEX_LSB = 1;
  localparam int DP_BIT  = 0;

  typedef struct packed {
    logic       en;
    logic [3:0] hex;
    logic       dp;
  } field_t;

  // segments a..g, active-low, entry 15 first
  localparam logic [15:0][6:0] GLYPH = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };

  function automatic field_t field_at(
    input logic [BUS_W-1:0] w,
    input logic [2:0]       i
  );
    logic [FW-1:0] f;
    f = w[i*FW +: FW];
    return '{en:  f[EN_BIT],
             hex: f[HEX_LSB +: 4],
             dp:  f[DP_BIT]};
  endfunction

endpackage

// File: rtl/disp_scan_if.sv
// Load/digit bus and display pins of the scanner.
interface disp_scan_if;
  import disp_pkg::*;

  logic             load;
  logic [BUS_W-1:0] digits;
  logic [7:0]       an;
  logic [7:0]       dec_ddp;
  logic             frame;

  modport master (
    output load, digits,
    input  an, dec_ddp, frame
  );

  modport slave (
    input  load, digits,
    output an, dec_ddp, frame
  );
endinterface

// File: rtl/seg7_dec.sv
// Hex-to-seven-segment glyph decode, active-low, dp in bit 0.
module seg7_dec
  import disp_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {GLYPH[hex], ~dp};

endmodule

// File: rtl/disp_scan.sv
// Time-multiplexed 8-digit scanner with a shadow buffer that is
// swapped into the active buffer only at frame boundaries.
module disp_scan
  import disp_pkg::*;
#(
  parameter int DIV   = 100000,
  parameter int BLANK = 1
) (
  input  logic      clock,
  input  logic      reset,
  disp_scan_if.slave bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0]    pcnt, pcnt_n;
  logic [2:0]       idx, idx_n;
  logic             pending;
  logic [BUS_W-1:0] shadow, active, act_n;
  logic             tick, wrap, xfer, dark;
  field_t           fld;
  logic [7:0]       seg;

  assign tick   = (pcnt == PW'(DIV - 1));
  assign wrap   = tick && (idx == 3'd7);
  assign xfer   = wrap && pending;
  assign pcnt_n = tick ? '0 : pcnt + 1'b1;
  assign idx_n  = idx + 3'(tick);
  assign act_n  = xfer ? shadow : active;

  // outputs look at the slot being entered, so decode the next state
  assign fld  = field_at(act_n, idx_n);
  assign dark = (32'(pcnt_n) < 32'(BLANK)) || !fld.en;

  seg7_dec u_dec (
    .hex (fld.hex),
    .dp  (fld.dp),
    .seg (seg)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      pcnt        <= '0;
      idx         <= '0;
      pending     <= 1'b0;
      shadow      <= '0;
      active      <= '0;
      bus.an      <= 8'hFF;
      bus.dec_ddp <= 8'hFF;
      bus.frame   <= 1'b0;
    end else begin
      pcnt   <= pcnt_n;
      idx    <= idx_n;
      active <= act_n;
      if (bus.load) begin
        shadow  <= bus.digits;
        pending <= 1'b1;
      end else if (xfer) begin
        pending <= 1'b0;
      end
      bus.frame <= wrap;
      if (dark) begin
        bus.an      <= 8'hFF;
        bus.dec_ddp <= 8'hFF;
      end else begin
        bus.an      <= ~(8'b1 << idx_n);
        bus.dec_ddp <= seg;
      end
    end
  end

endmodule

// File: tb/tb_disp_scan.sv
// Randomized bench for disp_scan against a cycle-count based
// reference model of slots, frames and buffer swaps.
module tb_disp_scan;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FR    = 8 * DIV;

  // glyphs as active-high abcdefg
  localparam logic [6:0] SEG_HI [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  logic clock = 1'b0;
  logic reset;

  disp_scan_if bus ();

  disp_scan #(
    .DIV   (DIV),
    .BLANK (BLANK)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  int          n;
  logic [47:0] m_sh, m_act;
  bit          m_pend;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h n=%0d t=%0t",
               tag, got, exp, n, $time);
    end
  endtask

  task automatic compare();
    int         slot, ph;
    logic [5:0] f;
    logic [7:0] e_an, e_seg;
    slot = (n / DIV) % 8;
    ph   = n % DIV;
    f    = m_act[slot*6 +: 6];
    if (ph < BLANK || !f[5]) begin
      e_an  = 8'hFF;
      e_seg = 8'hFF;
    end else begin
      e_an  = 8'hFF;
      e_an[slot] = 1'b0;
      e_seg = {~SEG_HI[f[4:1]], ~f[0]};
    end
    chk("an", 32'(bus.an), 32'(e_an));
    chk("dec_ddp", 32'(bus.dec_ddp), 32'(e_seg));
    chk("frame", 32'(bus.frame),
        32'((n > 0) && (n % FR == 0)));
  endtask

  task automatic cyc(
    input bit          r,
    input bit          ld,
    input logic [47:0] d
  );
    @(negedge clock);
    reset      = r;
    bus.load   = ld;
    bus.digits = d;
    @(posedge clock);
    if (r) begin
      n      = 0;
      m_sh   = '0;
      m_act  = '0;
      m_pend = 1'b0;
    end else begin
      n++;
      if (n % FR == 0 && m_pend) begin
        m_act  = m_sh;
        m_pend = 1'b0;
      end
      if (ld) begin
        m_sh   = d;
        m_pend = 1'b1;
      end
    end
    #1;
    compare();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, '0);
  endtask

  // advance until the next edge would leave n % FR == tgt
  task automatic run_to(input int tgt);
    for (int i = 0; i < FR; i++) begin
      if ((n + 1) % FR == tgt) break;
      cyc(1'b0, 1'b0, '0);
    end
  endtask

  function automatic logic [47:0] rnd48();
    return 48'({$urandom(), $urandom()});
  endfunction

  initial begin
    logic [47:0] a, b;
    n          = 0;
    m_sh       = '0;
    m_act      = '0;
    m_pend     = 1'b0;
    reset      = 1'b1;
    bus.load   = 1'b0;
    bus.digits = '0;

    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    idle(2 * FR + 5);

    cyc(1'b0, 1'b1, 48'h26);
    idle(2 * FR);

    cyc(1'b0, 1'b1, {6'h3F, 42'h0});
    idle(2 * FR);

    a = rnd48();
    cyc(1'b0, 1'b1, a);
    run_to(0);
    idle(FR);
    run_to(3 * DIV + 1);
    cyc(1'b0, 1'b1, rnd48());
    idle(2 * FR);

    a = rnd48();
    b = rnd48();
    cyc(1'b0, 1'b1, a);
    run_to(0);
    cyc(1'b0, 1'b1, b);
    idle(2 * FR + 3);

    for (int i = 0; i < 3; i++) begin
      idle(5);
      cyc(1'b0, 1'b1, rnd48());
    end
    idle(2 * FR);

    run_to(5 * DIV + 2);
    cyc(1'b1, 1'b0, '0);
    idle(2 * FR);
    cyc(1'b0, 1'b1, rnd48());
    idle(2 * FR);

    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom % 300) == 0,
          ($urandom % 20) == 0,
          rnd48());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
